uart_rx_fifo: RTL and testbench

//  Parametrised UART receiver for the Bluetooth-module serial link (8N1 today, configurable).

---
 rtl/uart_rx_fifo.sv | 138 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver (5-8 data bits, optional parity, 1-2 stop bits)
// with sticky error flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int DELAY_FRAMES = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rx,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    input  logic                        clr_err
);
    localparam int            CW   = $clog2(DELAY_FRAMES);
    localparam int            AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF = CW'(DELAY_FRAMES / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DELAY_FRAMES - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BREAK} state_t;

    state_t               state;
    logic                 rx_m, rx_s;
    logic [CW-1:0]        cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad, commit;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic                 pop, good, push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // commit pulses the cycle after the last good stop sample; the FIFO side resolves it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shreg     <= '0;
            par_bad   <= 1'b0;
            commit    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            commit <= 1'b0;
            cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
            if (clr_err) frame_err <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state   <= START;
                    busy    <= 1'b1;
                    cnt     <= '0;
                    par_bad <= 1'b0;
                end
                START: if (cnt == HALF) begin
                    state    <= rx_s ? IDLE : DATA;
                    busy     <= !rx_s;
                    cnt      <= '0;
                    bit_idx  <= '0;
                    stop_idx <= 1'b0;
                end
                DATA: if (cnt == LAST) begin
                    shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) state <= (PARITY != 0) ? PAR : STOP;
                end
                PAR: if (cnt == LAST) begin
                    par_bad <= rx_s != ((^shreg) ^ (PARITY == 2));
                    state   <= STOP;
                end
                STOP: if (cnt == LAST) begin
                    stop_idx <= 1'b1;
                    if (!rx_s) begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end else if (stop_idx == 1'(STOP_BITS - 1)) begin
                        commit <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                BREAK: if (rx_s) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pop      = rx_valid & rx_ready;
    assign good     = commit & ~par_bad;
    assign push     = good & (~fifo_count[AW] | pop);
    assign rx_valid = |fifo_count;
    assign rx_data  = rx_valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            wptr       <= wptr + AW'(push);
            rptr       <= rptr + AW'(pop);
            fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
            parity_err <= (commit & par_bad) | (parity_err & ~clr_err);
            overrun    <= (good & fifo_count[AW] & ~pop) | (overrun & ~clr_err);
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives an 8N1 receiver and an 8-odd-2 receiver with directed and random
// frames, checking both against a queue-level model of received characters and sticky flags.
module tb_uart_rx_fifo;
    localparam int DF    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       line0 = 1'b1, line1 = 1'b1;
    logic       rdy0 = 1'b0, rdy1 = 1'b0, clr0 = 1'b0, clr1 = 1'b0;
    logic [7:0] d0, d1;
    logic [2:0] c0, c1;
    logic       v0, v1, b0, b1, fe0, fe1, pe0, pe1, ov0, ov1;

    int         n_chk = 0;
    int         n_fail = 0;
    bit         chk_en = 1'b0;
    bit         saw [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         efe [2], epe [2], eov [2];
    typedef struct { int inst; logic [7:0] d; bit bad_par; bit bad_stop; } frame_t;
    frame_t     pend [$];

    always #5 clk = ~clk;

    uart_rx_fifo u0 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .fifo_count(c0), .busy(b0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .clr_err(clr0)
    );

    uart_rx_fifo #(.PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .rst_n(rst_n), .uart_rx(line1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .fifo_count(c1), .busy(b1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .clr_err(clr1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int msize(input int i);
        if (i == 1) return q1.size();
        return q0.size();
    endfunction

    function automatic logic [7:0] mhead(input int i);
        if (i == 1) return q1[0];
        return q0[0];
    endfunction

    task automatic mpush(input int i, input logic [7:0] d);
        if (i == 1) q1.push_back(d);
        else q0.push_back(d);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        pend.delete();
        for (int k = 0; k < 2; k++) begin
            efe[k] = 0;
            epe[k] = 0;
            eov[k] = 0;
        end
    endtask

    task automatic check_inst(input int i, input logic v, input logic [7:0] d, input logic [2:0] c,
                              input logic b, input logic fe, input logic pe, input logic ov);
        chk($sformatf("u%0d rx_valid", i), v, msize(i) != 0);
        chk($sformatf("u%0d fifo_count", i), c, msize(i));
        if (msize(i) != 0) chk($sformatf("u%0d rx_data", i), d, mhead(i));
        chk($sformatf("u%0d busy idle", i), b, 0);
        chk($sformatf("u%0d frame_err", i), fe, efe[i]);
        chk($sformatf("u%0d parity_err", i), pe, epe[i]);
        chk($sformatf("u%0d overrun", i), ov, eov[i]);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_inst(0, v0, d0, c0, b0, fe0, pe0, ov0);
            check_inst(1, v1, d1, c1, b1, fe1, pe1, ov1);
        end
        if (b0) saw[0] = 1;
        if (b1) saw[1] = 1;
    end

    // model side of the pop / clear handshakes, taken on the same edge the DUT sees them
    always @(posedge clk) begin
        if (rdy0 && q0.size() > 0) void'(q0.pop_front());
        if (rdy1 && q1.size() > 0) void'(q1.pop_front());
        if (clr0) begin efe[0] = 0; epe[0] = 0; eov[0] = 0; end
        if (clr1) begin efe[1] = 0; epe[1] = 0; eov[1] = 0; end
    end

    task automatic drive(input int i, input logic v);
        if (i == 1) line1 = v;
        else line0 = v;
    endtask

    task automatic set_rdy(input int i, input logic v);
        if (i == 1) rdy1 = v;
        else rdy0 = v;
    endtask

    task automatic set_clr(input int i, input logic v);
        if (i == 1) clr1 = v;
        else clr0 = v;
    endtask

    task automatic bit_time(input int i, input logic v);
        drive(i, v);
        repeat (DF) @(negedge clk);
    endtask

    task automatic send(input int i, input logic [7:0] d, input bit bad_par, input bit bad_stop,
                        input int hold);
        logic par;
        int   nstop, bad_at;
        frame_t f;
        chk_en = 0;
        par    = ~(^d) ^ bad_par;
        nstop  = (i == 1) ? 2 : 1;
        bad_at = (i == 1) ? int'($urandom_range(1)) : 0;
        bit_time(i, 1'b0);
        for (int k = 0; k < 8; k++) bit_time(i, d[k]);
        if (i == 1) bit_time(i, par);
        for (int k = 0; k < nstop; k++) begin
            if (bad_stop && k == bad_at) begin
                bit_time(i, 1'b0);
                repeat (hold) bit_time(i, 1'b0);
                break;
            end
            bit_time(i, 1'b1);
        end
        drive(i, 1'b1);
        f = '{i, d, bad_par, bad_stop};
        pend.push_back(f);
    endtask

    task automatic settle();
        frame_t f;
        drive(0, 1'b1);
        drive(1, 1'b1);
        repeat (DF) @(negedge clk);
        while (pend.size() > 0) begin
            f = pend.pop_front();
            if (f.bad_stop) efe[f.inst] = 1;
            else if (f.bad_par) epe[f.inst] = 1;
            else if (msize(f.inst) == DEPTH) eov[f.inst] = 1;
            else mpush(f.inst, f.d);
        end
        chk_en = 1;
    endtask

    task automatic pop_n(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            set_rdy(i, 1'($urandom_range(1)));
            @(negedge clk);
        end
        set_rdy(i, 1'b0);
    endtask

    task automatic pulse_clr(input int i);
        set_clr(i, 1'b1);
        @(negedge clk);
        set_clr(i, 1'b0);
    endtask

    task automatic glitch(input int i, input int g);
        chk_en = 0;
        saw[i] = 0;
        drive(i, 1'b0);
        repeat (g) @(negedge clk);
        drive(i, 1'b1);
        settle();
        chk($sformatf("u%0d glitch busy pulse", i), saw[i], 1);
    endtask

    // raises rx_ready (or clr_err) during the commit cycle, found as the first idle cycle after busy
    task automatic at_commit(input int i, input bit use_clr);
        int t;
        t = 0;
        while (!((i == 1) ? b1 : b0) && t < 200) begin @(negedge clk); t++; end
        while (((i == 1) ? b1 : b0) && t < 400) begin @(negedge clk); t++; end
        chk($sformatf("u%0d commit watch in time", i), t < 400, 1);
        if (use_clr) set_clr(i, 1'b1);
        else set_rdy(i, 1'b1);
        @(negedge clk);
        set_clr(i, 1'b0);
        set_rdy(i, 1'b0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset rx_valid", v0, 0);
        chk("reset rx_data", d0, 0);
        chk("reset fifo_count", c0, 0);
        chk("reset busy", b0, 0);
        chk("reset errors", {fe0, pe0, ov0, fe1, pe1, ov1}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1;

        send(0, 8'h41, 0, 0, 0);
        settle();
        chk("8N1 0x41 valid", v0, 1);
        chk("8N1 0x41 data", d0, 8'h41);
        chk("8N1 0x41 count", c0, 1);
        set_rdy(0, 1'b1);
        @(negedge clk);
        set_rdy(0, 1'b0);
        chk("pop empties", v0, 0);

        send(1, 8'h41, 0, 0, 0);
        settle();
        chk("odd parity 0x41 data", d1, 8'h41);
        chk("odd parity 0x41 flag", pe1, 0);
        pop_n(1, 6);
        send(1, 8'h41, 1, 0, 0);
        settle();
        chk("bad parity flag", pe1, 1);
        chk("bad parity discarded", c1, 0);
        pulse_clr(1);
        chk("parity clear", pe1, 0);

        send(0, 8'h55, 0, 1, 4);
        settle();
        chk("break frame_err", fe0, 1);
        chk("break fifo empty", c0, 0);
        pulse_clr(0);
        repeat (2 * DF) @(negedge clk);
        chk("break single error", fe0, 0);
        send(0, 8'h33, 0, 0, 0);
        settle();
        chk("after break 0x33", d0, 8'h33);
        pop_n(0, 8);
        set_rdy(0, 1'b1);
        @(negedge clk);
        set_rdy(0, 1'b0);

        for (int k = 1; k <= 5; k++) send(0, 8'(k), 0, 0, 0);
        settle();
        chk("overrun count", c0, 4);
        chk("overrun flag", ov0, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("overrun pop order", d0, k);
            set_rdy(0, 1'b1);
            @(negedge clk);
            set_rdy(0, 1'b0);
        end
        pulse_clr(0);
        chk("overrun clear", ov0, 0);

        for (int k = 0; k < 4; k++) send(0, 8'(8'h10 + k), 0, 0, 0);
        settle();
        fork
            send(0, 8'h14, 0, 0, 0);
            at_commit(0, 0);
        join
        settle();
        chk("push+pop full count", c0, 4);
        chk("push+pop full head", d0, 8'h11);
        chk("push+pop full no overrun", ov0, 0);
        pop_n(0, 10);

        fork
            send(1, 8'hC3, 1, 0, 0);
            at_commit(1, 1);
        join
        settle();
        chk("set wins over clear", pe1, 1);
        pulse_clr(1);

        glitch(0, 3);
        glitch(1, 1);

        for (int it = 0; it < 60; it++) begin
            int i, act;
            i   = $urandom_range(1);
            act = $urandom_range(5);
            case (act)
                0, 1: begin
                    n = $urandom_range(3, 1);
                    repeat (n) send(i, 8'($urandom), 0, 0, 0);
                    settle();
                end
                2: begin
                    send(i, 8'($urandom), i == 1 && $urandom_range(1) == 1,
                         i == 0 || $urandom_range(1) == 1, $urandom_range(2));
                    settle();
                end
                3: glitch(i, $urandom_range(3, 1));
                4: pop_n(i, $urandom_range(12));
                default: pulse_clr(i);
            endcase
        end

        set_rdy(0, 1'b1);
        repeat (DEPTH + 1) @(negedge clk);
        set_rdy(0, 1'b0);
        send(0, 8'hA1, 0, 0, 0);
        send(0, 8'hA2, 0, 0, 0);
        settle();
        chk("two queued", c0, 2);
        chk_en = 0;
        drive(0, 1'b0);
        repeat (DF) @(negedge clk);
        drive(0, 1'b1);
        repeat (DF) @(negedge clk);
        drive(0, 1'b0);
        repeat (DF / 2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset rx_valid", v0, 0);
        chk("async reset rx_data", d0, 0);
        chk("async reset fifo_count", c0, 0);
        chk("async reset busy", b0, 0);
        chk("async reset flags", {fe0, pe0, ov0}, 0);
        chk("async reset u1 count", c1, 0);
        model_reset();
        drive(0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        send(0, 8'h7E, 0, 0, 0);
        settle();
        chk("post reset 0x7E", d0, 8'h7E);
        chk("post reset count", c0, 1);
        repeat (2) @(negedge clk);
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
